// File: rtl/lisp_defs.sv
// lisp_defs: tagged-word layout, type tags, error codes and printer FSM states.
package lisp_defs;
  localparam int WordW = 16;
  localparam int TypeW = 3;
  localparam int AddrW = 12;
  localparam logic [TypeW-1:0] TYPE_NUMBER = 3'd1;
  localparam logic [TypeW-1:0] TYPE_CONS = 3'd2;
  localparam logic [WordW-1:0] LISP_NIL = 16'h0000;
  typedef enum logic [2:0] {
    ERR_NONE = 3'd0,
    ERR_TYPE = 3'd1,
    ERR_NESTED = 3'd2,
    ERR_ADDR = 3'd3,
    ERR_IMPROPER = 3'd4,
    ERR_LOOP = 3'd5
  } err_e;
  typedef enum logic [2:0] {Idle, FetchCar, FetchNum, Emit, FetchCdr, Done} state_e;
endpackage

// File: rtl/result_printer.sv
// result_printer: walks a flat list of numbers in memory and streams each value out.
module result_printer
  import lisp_defs::*;
#(
  parameter int unsigned MaxLen = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [WordW-1:0]         root,
  output logic                     mem_rd_en,
  output logic [AddrW-1:0]         mem_addr,
  input  logic [WordW-1:0]         mem_rdata,
  output logic                     out_valid,
  output logic [WordW-1:0]         out_data,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic [2:0]               err,
  output logic [7:0]               count
);
  state_e state_q, state_d;
  err_e err_q, err_d;
  logic ph_q, ph_d, single_q, single_d;
  logic [AddrW-1:0] cell_q, cell_d, addr_q, addr_d;
  logic [WordW-1:0] data_q, data_d;
  logic [7:0] count_q, count_d;
  logic [TypeW-1:0] root_tag, rd_tag;
  logic [AddrW-1:0] root_addr, rd_addr;
  logic fetch, rd;
  assign root_tag = root[AddrW +: TypeW];
  assign root_addr = root[AddrW-1:0];
  assign rd_tag = mem_rdata[AddrW +: TypeW];
  assign rd_addr = mem_rdata[AddrW-1:0];
  assign fetch = state_q inside {FetchCar, FetchNum, FetchCdr};
  // cdr of cell 0 would underflow, so that fetch never issues a read
  assign rd = fetch && !ph_q && !(state_q == FetchCdr && cell_q == '0);
  assign mem_rd_en = rd;
  assign mem_addr = !rd ? '0 : state_q == FetchCdr ? cell_q - 12'd1 : state_q == FetchNum ? addr_q : cell_q;
  assign out_valid = state_q == Emit;
  assign out_data = data_q;
  assign busy = fetch || state_q == Emit;
  assign done = state_q == Done;
  assign err = err_q;
  assign count = count_q;
  always_comb begin
    state_d = state_q;
    err_d = err_q;
    ph_d = 1'b0;
    single_d = single_q;
    cell_d = cell_q;
    addr_d = addr_q;
    data_d = data_q;
    count_d = count_q;
    case (state_q)
      Idle: if (start) begin
        count_d = '0;
        err_d = ERR_NONE;
        cell_d = root_addr;
        addr_d = root_addr;
        single_d = root_tag == TYPE_NUMBER;
        if (root == LISP_NIL) state_d = Done;
        else if (root_tag == TYPE_NUMBER) state_d = FetchNum;
        else if (root_tag == TYPE_CONS) state_d = FetchCar;
        else begin
          state_d = Done;
          err_d = ERR_TYPE;
        end
      end
      FetchCar: if (!ph_q) ph_d = 1'b1;
      else if (rd_tag == TYPE_NUMBER) begin
        addr_d = rd_addr;
        state_d = FetchNum;
      end else begin
        state_d = Done;
        err_d = ERR_NESTED;
      end
      FetchNum: if (!ph_q) ph_d = 1'b1;
      else begin
        data_d = mem_rdata;
        state_d = Emit;
      end
      Emit: if (out_ready) begin
        count_d = count_q + 8'd1;
        state_d = single_q ? Done : FetchCdr;
      end
      FetchCdr: if (cell_q == '0) begin
        state_d = Done;
        err_d = ERR_ADDR;
      end else if (!ph_q) ph_d = 1'b1;
      else if (mem_rdata == LISP_NIL) state_d = Done;
      else if (rd_tag == TYPE_CONS) begin
        state_d = count_q == 8'(MaxLen) ? Done : FetchCar;
        err_d = count_q == 8'(MaxLen) ? ERR_LOOP : err_q;
        cell_d = rd_addr;
      end else begin
        state_d = Done;
        err_d = ERR_IMPROPER;
      end
      default: state_d = Idle;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= Idle;
      err_q <= ERR_NONE;
      ph_q <= 1'b0;
      single_q <= 1'b0;
      cell_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      err_q <= err_d;
      ph_q <= ph_d;
      single_q <= single_d;
      cell_q <= cell_d;
      addr_q <= addr_d;
      data_q <= data_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_result_printer.sv
// tb_result_printer: table-driven list walks plus hand-written timing, stall, loop and reset sequences.
module tb_result_printer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic [15:0] root = '0, mem_rdata = '0, out_data;
  logic mem_rd_en, out_valid, busy, done;
  logic [11:0] mem_addr;
  logic [2:0] err;
  logic [7:0] count;
  logic [15:0] mem [4096];
  int checks = 0, errors = 0, rd_cnt = 0, idle_rd = 0;
  result_printer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .root(root),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err), .count(count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata <= mem[mem_addr];
      rd_cnt <= rd_cnt + 1;
    end
  end
  always @(negedge clk) if (!busy && mem_rd_en) idle_rd <= idle_rd + 1;
  typedef struct {
    string nm;
    int img;
    logic [15:0] r;
    int n;
    logic [15:0] e0, e1;
    logic [2:0] er;
  } vec_t;
  vec_t v[7];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input int img);
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    if (img == 0) mem[1] = 16'hDEAD;
    else begin
      mem[2] = 16'hDEAD; mem[1] = 16'hBEEF;
      mem[4] = 16'h1002; mem[3] = img == 2 ? 16'h2004 : 16'h2006;
      mem[6] = 16'h1001; mem[5] = 16'h0000;
      mem[0] = 16'h1002; mem[10] = 16'h2004;
      mem[20] = 16'h1002; mem[19] = 16'h1001;
    end
  endtask
  task automatic run_case(input string nm, input logic [15:0] r, input int n,
                          input logic [15:0] e0, input logic [15:0] e1, input logic [2:0] er);
    int got = 0;
    bit seen = 0;
    root = r;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4000 && !seen; c++) begin
      if (out_valid && out_ready) begin
        chk({nm, "_elem"}, out_data, got == 0 ? e0 : e1);
        got++;
      end
      if (done) seen = 1;
      else tick();
    end
    chk({nm, "_done"}, seen, 1);
    chk({nm, "_count"}, count, n[7:0]);
    chk({nm, "_emitted"}, got, n);
    chk({nm, "_err"}, err, er);
    tick();
  endtask
  task automatic wait_valid(input string nm);
    int c = 0;
    while (!out_valid && c < 100) begin
      tick();
      c++;
    end
    chk({nm, "_valid_timeout"}, out_valid, 1);
  endtask
  initial begin
    int rd0;
    v[0] = '{"num", 0, 16'h1001, 1, 16'hDEAD, 16'h0000, 3'd0};
    v[1] = '{"list", 1, 16'h2004, 2, 16'hDEAD, 16'hBEEF, 3'd0};
    v[2] = '{"nil", 1, 16'h0000, 0, 16'h0000, 16'h0000, 3'd0};
    v[3] = '{"badtype", 1, 16'h3005, 0, 16'h0000, 16'h0000, 3'd1};
    v[4] = '{"cons0", 1, 16'h2000, 1, 16'hDEAD, 16'h0000, 3'd3};
    v[5] = '{"nested", 1, 16'h200A, 0, 16'h0000, 16'h0000, 3'd2};
    v[6] = '{"improper", 1, 16'h2014, 1, 16'hDEAD, 16'h0000, 3'd4};
    load(0);
    tick();
    tick();
    chk("reset_outputs", {out_valid, out_data, mem_rd_en, mem_addr, busy, done, err, count}, '0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      load(v[i].img);
      run_case(v[i].nm, v[i].r, v[i].n, v[i].e0, v[i].e1, v[i].er);
    end
    // first out_valid three cycles after start; start in Done is ignored
    load(0);
    root = 16'h1001;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_rd", {busy, mem_rd_en, mem_addr, out_valid}, {1'b1, 1'b1, 12'd1, 1'b0});
    tick();
    chk("t2_phase", {busy, mem_rd_en, out_valid}, 3'b100);
    tick();
    chk("t3_emit", {out_valid, out_data}, {1'b1, 16'hDEAD});
    tick();
    chk("t4_done", {done, busy, count, err}, {1'b1, 1'b0, 8'd1, 3'd0});
    root = 16'h3005;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("start_in_done", {done, busy, err}, 5'b0);
    root = 16'h0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("nil_latency", {done, busy, count}, {1'b1, 1'b0, 8'd0});
    tick();
    // stall in Emit, with a start pulse that must be ignored while busy
    load(1);
    out_ready = 1'b0;
    root = 16'h2004;
    start = 1'b1;
    tick();
    root = 16'h3005;
    tick();
    start = 1'b0;
    wait_valid("stall");
    rd0 = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", {out_valid, out_data, mem_rd_en}, {1'b1, 16'hDEAD, 1'b0});
      tick();
    end
    chk("stall_no_reads", rd_cnt, rd0);
    out_ready = 1'b1;
    for (int c = 0; c < 100 && !done; c++) tick();
    chk("stall_result", {done, count, err}, {1'b1, 8'd2, 3'd0});
    tick();
    load(2);
    run_case("loop", 16'h2004, 255, 16'hDEAD, 16'hDEAD, 3'd5);
    // reset in Emit drops the element and the walk
    load(1);
    out_ready = 1'b0;
    root = 16'h2004;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("rst");
    rst_n = 1'b0;
    tick();
    chk("rst_emit_outputs", {out_valid, out_data, mem_rd_en, mem_addr, busy, done, err, count}, '0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("rst_no_done", done, 0);
    run_case("after_rst", 16'h2004, 2, 16'hDEAD, 16'hBEEF, 3'd0);
    chk("rd_while_idle", idle_rd, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
